// File: rtl/control_pipeline.sv
// control_pipeline: RV32I control decode in ID, carried through registered
// ID/EX, EX/MEM and MEM/WB control stages. It detects load-use hazards,
// handles branch/jump flush and a global stall, and flags illegal encodings.
// Ports:
//   CLK, RESET            clock (rising edge), async active-high reset
//   INSTR, INSTR_VALID    instruction held in the IF/ID register
//   STALL_IN              freeze all three stages
//   FLUSH                 kill the ID instruction (taken branch/jump in EX)
//   HAZARD_STALL          combinational load-use stall request to IF/ID
//   EX_*                  ID/EX stage controls
//   MEM_*                 EX/MEM stage controls
//   WB_*                  MEM/WB stage controls
module control_pipeline #(
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned ALU_OP_W = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         INSTR,
  input  logic                INSTR_VALID,
  input  logic                STALL_IN,
  input  logic                FLUSH,
  output logic                HAZARD_STALL,
  output logic                EX_VALID,
  output logic                EX_ILLEGAL,
  output logic                EX_BRANCH,
  output logic                EX_JUMP,
  output logic                EX_PC_SELECT,
  output logic                EX_IMM_SELECT,
  output logic [ALU_OP_W-1:0] EX_ALU_OP,
  output logic [2:0]          EX_FUNC3,
  output logic                MEM_VALID,
  output logic                MEM_READ,
  output logic                MEM_WRITE,
  output logic [2:0]          MEM_FUNC3,
  output logic                WB_VALID,
  output logic                WB_WRITE_ENABLE,
  output logic                WB_DATA_MEM_SELECT,
  output logic                WB_JAL_SELECT,
  output logic [4:0]          WB_RD
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned OP_W  = 3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef struct packed {
    logic             valid;
    logic             illegal;
    logic             branch;
    logic             jump;
    logic             pc_select;
    logic             imm_select;
    logic [OP_W-1:0]  alu_op;
    logic [F3_W-1:0]  func3;
    logic             mem_read;
    logic             mem_write;
    logic             write_enable;
    logic             data_mem_select;
    logic             jal_select;
    logic [REG_W-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic             valid;
    logic             mem_read;
    logic             mem_write;
    logic [F3_W-1:0]  func3;
    logic             write_enable;
    logic             data_mem_select;
    logic             jal_select;
    logic [REG_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic             valid;
    logic             write_enable;
    logic             data_mem_select;
    logic             jal_select;
    logic [REG_W-1:0] rd;
  } mem_wb_t;

  logic [6:0]       opcode;
  logic [F3_W-1:0]  funct3;
  logic [6:0]       funct7;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;

  assign opcode = INSTR[6:0];
  assign rd     = INSTR[11:7];
  assign funct3 = INSTR[14:12];
  assign rs1    = INSTR[19:15];
  assign rs2    = INSTR[24:20];
  assign funct7 = INSTR[31:25];

  id_ex_t  raw;
  id_ex_t  dec;
  logic    legal;
  logic    raw_rs1;
  logic    raw_rs2;
  logic    uses_rs1;
  logic    uses_rs2;

  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  // Class decode: raw controls per opcode plus encoding legality
  always_comb begin
    raw     = '0;
    legal   = 1'b0;
    raw_rs1 = 1'b0;
    raw_rs2 = 1'b0;
    case (opcode)
      OPC_OP: begin
        raw.write_enable = 1'b1;
        raw_rs1          = 1'b1;
        raw_rs2          = 1'b1;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
        end else if (funct7 == F7_ALT) begin
          legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else if ((funct7 == F7_MEXT) && ENABLE_M) begin
          legal      = 1'b1;
          raw.alu_op = 3'b110;
        end
      end
      OPC_LOAD: begin
        raw.alu_op          = 3'b001;
        raw.imm_select      = 1'b1;
        raw.write_enable    = 1'b1;
        raw.mem_read        = 1'b1;
        raw.data_mem_select = 1'b1;
        raw_rs1             = 1'b1;
        legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OPC_JALR: begin
        raw.alu_op       = 3'b010;
        raw.imm_select   = 1'b1;
        raw.write_enable = 1'b1;
        raw.jump         = 1'b1;
        raw.jal_select   = 1'b1;
        raw_rs1          = 1'b1;
        legal            = (funct3 == 3'b000);
      end
      OPC_OPIMM: begin
        raw.alu_op       = 3'b011;
        raw.imm_select   = 1'b1;
        raw.write_enable = 1'b1;
        raw_rs1          = 1'b1;
        // Shift-immediates carry funct7 in the upper immediate bits
        case (funct3)
          3'b001:  legal = (funct7 == F7_BASE);
          3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        raw.alu_op     = 3'b100;
        raw.imm_select = 1'b1;
        raw.mem_write  = 1'b1;
        raw_rs1        = 1'b1;
        raw_rs2        = 1'b1;
        legal = funct3 inside {3'b000, 3'b001, 3'b010};
      end
      OPC_LUI: begin
        raw.alu_op       = 3'b101;
        raw.imm_select   = 1'b1;
        raw.write_enable = 1'b1;
        legal            = 1'b1;
      end
      OPC_AUIPC: begin
        raw.alu_op       = 3'b100;
        raw.imm_select   = 1'b1;
        raw.write_enable = 1'b1;
        raw.pc_select    = 1'b1;
        legal            = 1'b1;
      end
      OPC_BRANCH: begin
        raw.alu_op     = 3'b100;
        raw.imm_select = 1'b1;
        raw.branch     = 1'b1;
        raw.pc_select  = 1'b1;
        raw_rs1        = 1'b1;
        raw_rs2        = 1'b1;
        legal          = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_JAL: begin
        raw.alu_op       = 3'b100;
        raw.imm_select   = 1'b1;
        raw.write_enable = 1'b1;
        raw.jump         = 1'b1;
        raw.jal_select   = 1'b1;
        raw.pc_select    = 1'b1;
        legal            = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Final ID bundle: bubble, illegal marker, or legal decode with x0 write suppressed
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (INSTR_VALID) begin
      if (!legal) begin
        dec.valid   = 1'b1;
        dec.illegal = 1'b1;
      end else begin
        dec              = raw;
        dec.valid        = 1'b1;
        dec.func3        = funct3;
        dec.rd           = rd;
        dec.write_enable = raw.write_enable && (rd != '0);
        uses_rs1         = raw_rs1;
        uses_rs2         = raw_rs2;
      end
    end
  end

  // Load-use: the load in EX cannot forward to a consumer in ID; FLUSH overrides
  assign HAZARD_STALL = INSTR_VALID && id_ex_q.valid && id_ex_q.mem_read &&
                        (id_ex_q.rd != '0) &&
                        ((uses_rs1 && (rs1 == id_ex_q.rd)) ||
                         (uses_rs2 && (rs2 == id_ex_q.rd))) &&
                        !FLUSH;

  // Next-state for the three stage registers
  always_comb begin
    id_ex_d  = id_ex_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    if (!STALL_IN) begin
      mem_wb_d.valid           = ex_mem_q.valid;
      mem_wb_d.write_enable    = ex_mem_q.write_enable;
      mem_wb_d.data_mem_select = ex_mem_q.data_mem_select;
      mem_wb_d.jal_select      = ex_mem_q.jal_select;
      mem_wb_d.rd              = ex_mem_q.rd;

      ex_mem_d.valid           = id_ex_q.valid;
      ex_mem_d.mem_read        = id_ex_q.mem_read;
      ex_mem_d.mem_write       = id_ex_q.mem_write;
      ex_mem_d.func3           = id_ex_q.func3;
      ex_mem_d.write_enable    = id_ex_q.write_enable;
      ex_mem_d.data_mem_select = id_ex_q.data_mem_select;
      ex_mem_d.jal_select      = id_ex_q.jal_select;
      ex_mem_d.rd              = id_ex_q.rd;

      if (FLUSH || HAZARD_STALL) begin
        id_ex_d = '0;
      end else begin
        id_ex_d = dec;
      end
    end
  end

  // Stage registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign EX_VALID           = id_ex_q.valid;
  assign EX_ILLEGAL         = id_ex_q.illegal;
  assign EX_BRANCH          = id_ex_q.branch;
  assign EX_JUMP            = id_ex_q.jump;
  assign EX_PC_SELECT       = id_ex_q.pc_select;
  assign EX_IMM_SELECT      = id_ex_q.imm_select;
  assign EX_ALU_OP          = ALU_OP_W'(id_ex_q.alu_op);
  assign EX_FUNC3           = id_ex_q.func3;
  assign MEM_VALID          = ex_mem_q.valid;
  assign MEM_READ           = ex_mem_q.mem_read;
  assign MEM_WRITE          = ex_mem_q.mem_write;
  assign MEM_FUNC3          = ex_mem_q.func3;
  assign WB_VALID           = mem_wb_q.valid;
  assign WB_WRITE_ENABLE    = mem_wb_q.write_enable;
  assign WB_DATA_MEM_SELECT = mem_wb_q.data_mem_select;
  assign WB_JAL_SELECT      = mem_wb_q.jal_select;
  assign WB_RD              = mem_wb_q.rd;

endmodule
